// File: rtl/alu_instr_sequencer.sv
// Multi-cycle strobe sequencer for one register-register ALU instruction per start.
// Define SEQ_R0_WRITE_PROTECT_EN to suppress register writes to R0 in T5.
module alu_instr_sequencer #(
    parameter logic [4:0] OPC_MUL     = 5'b01111,
    parameter logic [4:0] OPC_DIV     = 5'b10000,
    parameter logic [4:0] OPC_MAX     = 5'b10000,
    parameter logic [3:0] MEM_TIMEOUT = 4'd15
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        pc_out,
    output logic        mar_in,
    output logic        inc_pc,
    output logic        z_in,
    output logic        zlo_out,
    output logic        zhi_out,
    output logic        pc_in,
    output logic        mdr_read,
    output logic        mdr_in,
    output logic        mdr_out,
    output logic        ir_in,
    output logic        y_in,
    output logic        lo_in,
    output logic        hi_in,
    output logic [15:0] reg_in,
    output logic [15:0] reg_out,
    output logic [4:0]  alu_sel,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_DEC   = 4'd4,
        S_T3    = 4'd5,
        S_T4    = 4'd6,
        S_T5    = 4'd7,
        S_T6    = 4'd8,
        S_DONE  = 4'd9,
        S_FAULT = 4'd10
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  wait_cnt;
    logic [3:0]  wait_inc;
    logic        mem_timeout;
    logic [4:0]  op_q;
    logic [3:0]  ra_q, rb_q, rc_q;
    logic [1:0]  cause_q;
    logic        wide_op;
    logic        op_illegal;
    logic        unused_ir;

    assign wait_inc    = wait_cnt + 4'd1;
    assign mem_timeout = (wait_inc == MEM_TIMEOUT);
    assign wide_op     = (op_q == OPC_MUL) || (op_q == OPC_DIV);
    assign op_illegal  = (ir[31:27] > OPC_MAX);
    assign unused_ir   = ^ir[14:0];

    function automatic logic [15:0] onehot(input logic [3:0] idx);
        onehot = 16'h0001 << idx;
    endfunction

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Wait counter, latched instruction fields and sticky fault cause.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wait_cnt <= 4'd0;
            op_q     <= 5'd0;
            ra_q     <= 4'd0;
            rb_q     <= 4'd0;
            rc_q     <= 4'd0;
            cause_q  <= 2'b00;
        end else begin
            case (state)
                S_IDLE: if (start) cause_q <= 2'b00;
                S_T0:   wait_cnt <= 4'd0;
                S_T1: begin
                    if (!mem_ready) begin
                        wait_cnt <= wait_inc;
                        if (mem_timeout) cause_q <= 2'b10;
                    end
                end
                S_DEC: begin
                    op_q <= ir[31:27];
                    ra_q <= ir[26:23];
                    rb_q <= ir[22:19];
                    rc_q <= ir[18:15];
                    if (op_illegal) cause_q <= 2'b01;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = S_IDLE;
        case (state)
            S_IDLE:  state_nx = start ? S_T0 : S_IDLE;
            S_T0:    state_nx = S_T1;
            S_T1: begin
                if (mem_ready)        state_nx = S_T2;
                else if (mem_timeout) state_nx = S_FAULT;
                else                  state_nx = S_T1;
            end
            S_T2:    state_nx = S_DEC;
            S_DEC:   state_nx = op_illegal ? S_FAULT : S_T3;
            S_T3:    state_nx = S_T4;
            S_T4:    state_nx = S_T5;
            S_T5:    state_nx = wide_op ? S_T6 : S_DONE;
            S_T6:    state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            S_FAULT: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != S_IDLE);
        done        = 1'b0;
        fault       = 1'b0;
        fault_cause = cause_q;
        pc_out      = 1'b0;
        mar_in      = 1'b0;
        inc_pc      = 1'b0;
        z_in        = 1'b0;
        zlo_out     = 1'b0;
        zhi_out     = 1'b0;
        pc_in       = 1'b0;
        mdr_read    = 1'b0;
        mdr_in      = 1'b0;
        mdr_out     = 1'b0;
        ir_in       = 1'b0;
        y_in        = 1'b0;
        lo_in       = 1'b0;
        hi_in       = 1'b0;
        reg_in      = 16'h0000;
        reg_out     = 16'h0000;
        alu_sel     = 5'd0;
        state_dbg   = state;
        case (state)
            S_T0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
                z_in   = 1'b1;
            end
            S_T1: begin
                // wait_cnt is cleared in T0, so zero marks the first T1 cycle
                zlo_out  = 1'b1;
                pc_in    = (wait_cnt == 4'd0);
                mdr_read = 1'b1;
                mdr_in   = 1'b1;
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            S_T3: begin
                reg_out = onehot(rb_q);
                y_in    = 1'b1;
            end
            S_T4: begin
                reg_out = onehot(rc_q);
                alu_sel = op_q;
                z_in    = 1'b1;
            end
            S_T5: begin
                zlo_out = 1'b1;
                if (wide_op) begin
                    lo_in = 1'b1;
                end else begin
`ifdef SEQ_R0_WRITE_PROTECT_EN
                    reg_in = (ra_q == 4'd0) ? 16'h0000 : onehot(ra_q);
`else
                    reg_in = onehot(ra_q);
`endif
                end
            end
            S_T6: begin
                zhi_out = 1'b1;
                hi_in   = 1'b1;
            end
            S_DONE:  done = 1'b1;
            S_FAULT: begin
                done  = 1'b1;
                fault = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Bench for alu_instr_sequencer: per-cycle trace model built from the instruction's phase list.
module tb_alu_instr_sequencer;

    typedef struct packed {
        logic        busy, done, fault;
        logic [1:0]  cause;
        logic        pc_out, mar_in, inc_pc, z_in, zlo_out, zhi_out, pc_in;
        logic        mdr_read, mdr_in, mdr_out, ir_in, y_in, lo_in, hi_in;
        logic [15:0] reg_in, reg_out;
        logic [4:0]  alu_sel;
        logic [3:0]  state;
    } out_t;

    typedef struct {
        string       name;
        logic [31:0] iv;
        int          w;
        bit          rs;
        int          len;
        bit          flt;
        logic [1:0]  cause;
    } vec_t;

    logic        clk = 1'b0;
    logic        clr, start, mem_ready;
    logic [31:0] ir;
    logic        busy, done, fault;
    logic [1:0]  fault_cause;
    logic        pc_out, mar_in, inc_pc, z_in, zlo_out, zhi_out, pc_in;
    logic        mdr_read, mdr_in, mdr_out, ir_in, y_in, lo_in, hi_in;
    logic [15:0] reg_in, reg_out;
    logic [4:0]  alu_sel;
    logic [3:0]  state_dbg;

    out_t        dut_o;
    out_t        exp_q[$];
    logic [1:0]  cur_cause;
    logic [1:0]  trace_cause;
    int          checks = 0;
    int          errors = 0;

    alu_instr_sequencer dut (
        .clk(clk), .clr(clr), .start(start), .mem_ready(mem_ready), .ir(ir),
        .busy(busy), .done(done), .fault(fault), .fault_cause(fault_cause),
        .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .z_in(z_in),
        .zlo_out(zlo_out), .zhi_out(zhi_out), .pc_in(pc_in), .mdr_read(mdr_read),
        .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in),
        .lo_in(lo_in), .hi_in(hi_in), .reg_in(reg_in), .reg_out(reg_out),
        .alu_sel(alu_sel), .state_dbg(state_dbg)
    );

    assign dut_o = {busy, done, fault, fault_cause, pc_out, mar_in, inc_pc, z_in,
                    zlo_out, zhi_out, pc_in, mdr_read, mdr_in, mdr_out, ir_in, y_in,
                    lo_in, hi_in, reg_in, reg_out, alu_sel, state_dbg};

    always #5 clk = ~clk;

    function automatic out_t blank(input logic [1:0] fc, input logic [3:0] st);
        out_t o;
        o       = '0;
        o.cause = fc;
        o.state = st;
        o.busy  = (st != 4'd0);
        return o;
    endfunction

    // Expected outputs for each cycle after start is accepted, ending with one IDLE cycle.
    task automatic build_trace(input logic [31:0] iv, input int w);
        out_t       o;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        int         n_t1;
        bit         wide;
        op = iv[31:27]; ra = iv[26:23]; rb = iv[22:19]; rc = iv[18:15];
        exp_q.delete();
        o = blank(2'b00, 4'd1);
        o.pc_out = 1; o.mar_in = 1; o.inc_pc = 1; o.z_in = 1;
        exp_q.push_back(o);
        n_t1 = (w >= 15) ? 15 : w + 1;
        for (int i = 0; i < n_t1; i++) begin
            o = blank(2'b00, 4'd2);
            o.zlo_out = 1; o.pc_in = (i == 0); o.mdr_read = 1; o.mdr_in = 1;
            exp_q.push_back(o);
        end
        if (w >= 15) begin
            trace_cause = 2'b10;
        end else begin
            o = blank(2'b00, 4'd3); o.mdr_out = 1; o.ir_in = 1;
            exp_q.push_back(o);
            exp_q.push_back(blank(2'b00, 4'd4));
            if (op > 5'd16) begin
                trace_cause = 2'b01;
            end else begin
                trace_cause = 2'b00;
                wide = (op == 5'd15) || (op == 5'd16);
                o = blank(2'b00, 4'd5); o.reg_out = 16'(1) << rb; o.y_in = 1;
                exp_q.push_back(o);
                o = blank(2'b00, 4'd6); o.reg_out = 16'(1) << rc; o.alu_sel = op; o.z_in = 1;
                exp_q.push_back(o);
                o = blank(2'b00, 4'd7); o.zlo_out = 1;
                if (wide) o.lo_in = 1;
                else      o.reg_in = 16'(1) << ra;
`ifdef SEQ_R0_WRITE_PROTECT_EN
                if (!wide && ra == 4'd0) o.reg_in = 16'h0000;
`endif
                exp_q.push_back(o);
                if (wide) begin
                    o = blank(2'b00, 4'd8); o.zhi_out = 1; o.hi_in = 1;
                    exp_q.push_back(o);
                end
            end
        end
        o = blank(trace_cause, (trace_cause == 2'b00) ? 4'd9 : 4'd10);
        o.done  = 1;
        o.fault = (trace_cause != 2'b00);
        exp_q.push_back(o);
        exp_q.push_back(blank(trace_cause, 4'd0));
    endtask

    task automatic check(input string name, input out_t got, input out_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Called from an IDLE cycle, 1 time unit after the clock edge.
    task automatic run_instr(input logic [31:0] iv, input int w, input bit rs,
                             output int len, output bit flt, output logic [1:0] cause);
        int n;
        build_trace(iv, w);
        n = exp_q.size();
        ir = iv; start = 1'b1; mem_ready = 1'b0;
        len = 0; flt = 0; cause = 2'b11;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            start     = (rs && k < n) ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_ready = (k >= 2 + w);
            check($sformatf("cyc%0d ir=%h w=%0d", k, iv, w), dut_o, exp_q[k-1]);
            if (done && len == 0) begin
                len = k; flt = fault; cause = fault_cause;
            end
        end
        cur_cause = trace_cause;
    endtask

    vec_t       tbl[$];
    int         len;
    bit         flt;
    logic [1:0] cause;

    initial begin
        tbl.push_back('{"sub",        32'h20A28000, 0,  0, 8,  0, 2'b00});
        tbl.push_back('{"mul",        32'h78228000, 0,  0, 9,  0, 2'b00});
        tbl.push_back('{"div",        32'h80A28000, 0,  1, 9,  0, 2'b00});
        tbl.push_back('{"illegal31",  32'hF8000000, 0,  0, 5,  1, 2'b01});
        tbl.push_back('{"sub_after",  32'h20A28000, 0,  0, 8,  0, 2'b00});
        tbl.push_back('{"illegal17",  32'h88000000, 0,  1, 5,  1, 2'b01});
        tbl.push_back('{"timeout",    32'h20A28000, 20, 0, 17, 1, 2'b10});
        tbl.push_back('{"wait14",     32'h20A28000, 14, 1, 22, 0, 2'b00});
        tbl.push_back('{"wait3",      32'h20A28000, 3,  0, 11, 0, 2'b00});
        tbl.push_back('{"ra_zero",    32'h20228000, 0,  1, 8,  0, 2'b00});

        clr = 1'b1; start = 1'b0; mem_ready = 1'b0; ir = 32'h0;
        cur_cause = 2'b00;
        #3;
        check("reset_async", dut_o, blank(2'b00, 4'd0));
        @(posedge clk); @(posedge clk); #1;
        clr = 1'b0;
        check("reset_idle", dut_o, blank(2'b00, 4'd0));

        foreach (tbl[i]) begin
            run_instr(tbl[i].iv, tbl[i].w, tbl[i].rs, len, flt, cause);
            check_int({tbl[i].name, "_len"},   len,       tbl[i].len);
            check_int({tbl[i].name, "_fault"}, int'(flt), int'(tbl[i].flt));
            check_int({tbl[i].name, "_cause"}, int'(cause), int'(tbl[i].cause));
        end

        // Abandon an instruction with clr in T4.
        ir = 32'h20A28000; start = 1'b1; mem_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        check_int("clr_pre_state", int'(state_dbg), 6);
        #2 clr = 1'b1;
        #1 check("clr_async", dut_o, blank(2'b00, 4'd0));
        #1 clr = 1'b0;
        cur_cause = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("clr_idle%0d", k), dut_o, blank(2'b00, 4'd0));
        end
        run_instr(32'h20A28000, 0, 0, len, flt, cause);
        check_int("after_clr_len", len, 8);

        for (int r = 0; r < 40; r++) begin
            logic [4:0]  op;
            logic [31:0] iv;
            int          sel, w;
            sel = $urandom_range(0, 9);
            if (sel < 6)      op = 5'($urandom_range(0, 16));
            else if (sel < 8) op = (sel == 6) ? 5'd15 : 5'd16;
            else              op = 5'($urandom_range(17, 31));
            iv = $urandom;
            iv[31:27] = op;
            w = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
            run_instr(iv, w, 1'b1, len, flt, cause);
            check_int($sformatf("rand%0d_done_seen", r), int'(len > 0), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
